// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the 5-stage core.
// Produces enable/flush for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC
// enable from memory handshakes, load-use and mispredict, and runs the
// halt drain FSM (RUN -> DRAIN -> HALTED).
// Optional: define HAZARD_PERF_EN to add stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int REGW         = 5
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_access,
    input  logic            idex_memread,
    input  logic [REGW-1:0] idex_rd,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic            mispredict,
    input  logic            halt_id,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic            halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mem_busy, advance, lduse;

    assign mem_busy = mem_access & ~dhit;
    assign advance  = ~mem_busy;
    assign lduse    = idex_memread & (idex_rd != '0) &
                      ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

    // halted comes straight from the state register, so it clears with nRST
    assign halted = (state == HALTED);

    // State and drain counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Output decode and next-state logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    // full freeze: everything already at 0
                end else if (mispredict) begin
                    // squash the two wrong-path instructions, load corrected PC
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (lduse) begin
                    // hold IF/ID and PC, inject one bubble into EX
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (!ihit) begin
                    // no fetch yet: bubble into ID, let the rest drain forward
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
                // a coincident mispredict squashes the HALT
                if (halt_id & advance & ~mispredict & ~lduse & ihit) begin
                    state_n = DRAIN;
                    cnt_n   = CW'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                // nothing older than HALT can be a branch or load in EX
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = advance;
                exmem_en   = advance;
                memwb_en   = advance;
                if (advance) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1))
                        state_n = HALTED;
                end
            end
            HALTED: begin
                // terminal; only nRST leaves
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    // Stall and mispredict-flush event counters; both are RUN-only so they freeze when halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN && !pc_en)
                stall_cnt <= stall_cnt + 32'd1;
            if (state == RUN && !mem_busy && mispredict)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
